// File: rtl/player_bullet.sv
// -----------------------------------------------------------------------------
// player_bullet
//   Owns the player's single laser shot: launch from the gun, upward flight one
//   step per frame, hit or miss, then a short cooldown before the gun re-arms.
//   The bullet box is exclusive on all four sides, so a parked box (all zero)
//   draws nothing.
//
// Ports
//   clk_i          pixel clock
//   reset_i        asynchronous, active-high reset
//   frame_i        one-cycle strobe, once per frame
//   shoot_i        synchronized shoot button level
//   enable_i       player alive; low forbids firing and cancels a flight
//   gun_left_i     exclusive left bound of the gun
//   gun_right_i    exclusive right bound of the gun
//   hit_enemy_i    bullet overlapped an enemy this cycle
//   bullet_o       bullet in flight (state is FLYING)
//   bullet_*_o     registered exclusive bullet box bounds
//   pres_state_o   registered state (debug)
//   next_state_o   combinational next state (debug)
//
// Build option
//   PLAYER_BULLET_AUTOFIRE_EN : when defined, the shoot level (not a rising
//   edge) is the fire condition in IDLE, so holding the button relaunches on
//   the first frame after every re-arm.
// -----------------------------------------------------------------------------
module player_bullet #(
  parameter int WIDTH_P           = 2,
  parameter int HEIGHT_P          = 10,
  parameter int START_BOT_P       = 430,
  parameter int SPEED_P           = 4,
  parameter int TOP_LIMIT_P       = 0,
  parameter int COOLDOWN_FRAMES_P = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_i,
  input  logic       shoot_i,
  input  logic       enable_i,
  input  logic [9:0] gun_left_i,
  input  logic [9:0] gun_right_i,
  input  logic       hit_enemy_i,
  output logic       bullet_o,
  output logic [9:0] bullet_left_o,
  output logic [9:0] bullet_right_o,
  output logic [9:0] bullet_top_o,
  output logic [9:0] bullet_bot_o,
  output logic [1:0] pres_state_o,
  output logic [1:0] next_state_o
);

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  FLYING    = 2'd1;
  localparam logic [1:0]  COOLDOWN  = 2'd2;

  localparam logic [9:0]  WIDTH_L     = 10'(WIDTH_P);
  localparam logic [9:0]  START_BOT_L = 10'(START_BOT_P);
  localparam logic [9:0]  START_TOP_L = 10'(START_BOT_P - HEIGHT_P - 1);
  localparam logic [9:0]  SPEED_L     = 10'(SPEED_P);
  // 11 bits so the miss threshold itself cannot wrap.
  localparam logic [10:0] MISS_L      = 11'(TOP_LIMIT_P + SPEED_P);
  localparam logic [7:0]  COOL_L      = 8'(COOLDOWN_FRAMES_P);

  logic [1:0]  state_q, state_d;
  logic        fire_req_q, fire_req_d;
  logic        shoot_prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [9:0]  left_q, left_d;
  logic [9:0]  right_q, right_d;
  logic [9:0]  top_q, top_d;
  logic [9:0]  bot_q, bot_d;

  logic        fire_now;
  logic [10:0] gun_sum;
  logic [9:0]  center;

`ifdef PLAYER_BULLET_AUTOFIRE_EN
  assign fire_now = enable_i & shoot_i;
`else
  assign fire_now = enable_i & shoot_i & ~shoot_prev_q;
`endif

  // Full 11-bit sum so a gun near the right edge cannot wrap the center.
  assign gun_sum = {1'b0, gun_left_i} + {1'b0, gun_right_i};
  assign center  = 10'(gun_sum >> 1);

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d    = state_q;
    fire_req_d = fire_req_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    right_d    = right_q;
    top_d      = top_q;
    bot_d      = bot_q;

    case (state_q)
      IDLE: begin
        if (frame_i && enable_i && (fire_req_q || fire_now)) begin
          state_d    = FLYING;
          fire_req_d = 1'b0;
          left_d     = center - 10'd1;
          right_d    = center + WIDTH_L;
          top_d      = START_TOP_L;
          bot_d      = START_BOT_L;
        end else if (fire_now) begin
          fire_req_d = 1'b1;
        end
      end
      FLYING: begin
        fire_req_d = 1'b0;
        if (!enable_i) begin
          state_d = IDLE;
        end else if (hit_enemy_i) begin
          // A hit wins over a same-cycle frame move.
          state_d = COOLDOWN;
          cnt_d   = COOL_L;
        end else if (frame_i) begin
          if ({1'b0, top_q} < MISS_L) begin
            state_d = COOLDOWN;
            cnt_d   = COOL_L;
          end else begin
            top_d = top_q - SPEED_L;
            bot_d = bot_q - SPEED_L;
          end
        end
      end
      COOLDOWN: begin
        fire_req_d = 1'b0;
        if (!enable_i) begin
          state_d = IDLE;
        end else if (frame_i) begin
          if (cnt_q <= 8'd1) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        fire_req_d = 1'b0;
      end
    endcase

    // Any cycle that ends outside FLYING parks the box at zero.
    if (state_d != FLYING) begin
      left_d  = 10'd0;
      right_d = 10'd0;
      top_d   = 10'd0;
      bot_d   = 10'd0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fire_req_q   <= 1'b0;
      shoot_prev_q <= 1'b0;
      cnt_q        <= 8'd0;
      left_q       <= 10'd0;
      right_q      <= 10'd0;
      top_q        <= 10'd0;
      bot_q        <= 10'd0;
    end else begin
      fire_req_q   <= fire_req_d;
      shoot_prev_q <= shoot_i;
      cnt_q        <= cnt_d;
      left_q       <= left_d;
      right_q      <= right_d;
      top_q        <= top_d;
      bot_q        <= bot_d;
    end
  end

  // Outputs
  always_comb begin
    bullet_o       = (state_q == FLYING);
    bullet_left_o  = left_q;
    bullet_right_o = right_q;
    bullet_top_o   = top_q;
    bullet_bot_o   = bot_q;
    pres_state_o   = state_q;
    next_state_o   = state_d;
  end

endmodule

// File: tb/tb_player_bullet.sv
module tb_player_bullet;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       frame_i;
  logic       shoot_i;
  logic       enable_i;
  logic [9:0] gun_left_i;
  logic [9:0] gun_right_i;
  logic       hit_enemy_i;
  logic       bullet_o;
  logic [9:0] bullet_left_o;
  logic [9:0] bullet_right_o;
  logic [9:0] bullet_top_o;
  logic [9:0] bullet_bot_o;
  logic [1:0] pres_state_o;
  logic [1:0] next_state_o;

  always #5 clk_i = ~clk_i;

  player_bullet dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .frame_i        (frame_i),
    .shoot_i        (shoot_i),
    .enable_i       (enable_i),
    .gun_left_i     (gun_left_i),
    .gun_right_i    (gun_right_i),
    .hit_enemy_i    (hit_enemy_i),
    .bullet_o       (bullet_o),
    .bullet_left_o  (bullet_left_o),
    .bullet_right_o (bullet_right_o),
    .bullet_top_o   (bullet_top_o),
    .bullet_bot_o   (bullet_bot_o),
    .pres_state_o   (pres_state_o),
    .next_state_o   (next_state_o)
  );

  typedef struct {
    int st;
    int b;
    int l;
    int r;
    int t;
    int bt;
  } want_t;

  want_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the bullet behaviour.
  int m_st, m_l, m_r, m_t, m_b, m_cnt;
  bit m_req, m_prev;

  task automatic chk(input string tag, input int obs, input int want);
    n_checks++;
    if (obs != want) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_l = 0; m_r = 0; m_t = 0; m_b = 0; m_cnt = 0;
    m_req = 0; m_prev = 0;
  endtask

  // Drive one clock cycle of stimulus, push the model's prediction, then pop
  // and compare it against the registered outputs after the edge.
  task automatic cyc(input bit f, input bit s, input bit en, input bit h);
    want_t w;
    int    nx;
    int    c;
    bit    fire;
    frame_i     = f;
    shoot_i     = s;
    enable_i    = en;
    hit_enemy_i = h;
`ifdef PLAYER_BULLET_AUTOFIRE_EN
    fire = en && s;
`else
    fire = en && s && !m_prev;
`endif
    nx = m_st;
    case (m_st)
      0: begin
        if (f && en && (m_req || fire)) begin
          nx    = 1;
          m_req = 0;
          c     = (int'(gun_left_i) + int'(gun_right_i)) / 2;
          m_l   = c - 1;
          m_r   = c + 2;
          m_t   = 430 - 10 - 1;
          m_b   = 430;
        end else if (fire) begin
          m_req = 1;
        end
      end
      1: begin
        m_req = 0;
        if (!en) nx = 0;
        else if (h) begin nx = 2; m_cnt = 8; end
        else if (f) begin
          if (m_t < 4) begin nx = 2; m_cnt = 8; end
          else begin m_t -= 4; m_b -= 4; end
        end
      end
      default: begin
        m_req = 0;
        if (!en) nx = 0;
        else if (f) begin
          if (m_cnt == 1) nx = 0;
          m_cnt--;
        end
      end
    endcase
    m_prev = s;
    #1;
    chk("next_state", int'(next_state_o), nx);
    m_st = nx;
    if (nx != 1) begin m_l = 0; m_r = 0; m_t = 0; m_b = 0; end
    w.st = m_st; w.b = (m_st == 1); w.l = m_l; w.r = m_r; w.t = m_t; w.bt = m_b;
    sb.push_back(w);
    @(posedge clk_i);
    #1;
    w = sb.pop_front();
    chk("state", int'(pres_state_o), w.st);
    chk("bullet", int'(bullet_o), w.b);
    chk("left", int'(bullet_left_o), w.l);
    chk("right", int'(bullet_right_o), w.r);
    chk("top", int'(bullet_top_o), w.t);
    chk("bot", int'(bullet_bot_o), w.bt);
  endtask

  task automatic chk_parked(input string tag);
    chk({tag, "_bullet"}, int'(bullet_o), 0);
    chk({tag, "_left"}, int'(bullet_left_o), 0);
    chk({tag, "_right"}, int'(bullet_right_o), 0);
    chk({tag, "_top"}, int'(bullet_top_o), 0);
    chk({tag, "_bot"}, int'(bullet_bot_o), 0);
  endtask

  initial begin
    reset_i = 1'b1; frame_i = 1'b0; shoot_i = 1'b0; enable_i = 1'b1;
    hit_enemy_i = 1'b0; gun_left_i = 10'd310; gun_right_i = 10'd330;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk_parked("reset");
    chk("reset_state", int'(pres_state_o), 0);
    reset_i = 1'b0;

    // Launch: edge registers a request, the next frame launches.
    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    chk("launch_bullet", int'(bullet_o), 1);
    chk("launch_left", int'(bullet_left_o), 319);
    chk("launch_right", int'(bullet_right_o), 322);
    chk("launch_top", int'(bullet_top_o), 419);
    chk("launch_bot", int'(bullet_bot_o), 430);

    // Flight with a shoot press mid-flight that must be dropped.
    for (int i = 1; i <= 104; i++) begin
      cyc(0, (i == 50), 1, 0);
      cyc(1, 0, 1, 0);
    end
    chk("fly104_top", int'(bullet_top_o), 3);
    chk("fly104_bot", int'(bullet_bot_o), 14);
    chk("fly104_bullet", int'(bullet_o), 1);
    cyc(1, 0, 1, 0);
    chk("miss_state", int'(pres_state_o), 2);
    chk_parked("miss");

    // Cooldown with a press that must also be dropped.
    for (int k = 0; k < 8; k++) begin
      cyc(0, (k == 3), 1, 0);
      cyc(1, 0, 1, 0);
    end
    chk("rearm_state", int'(pres_state_o), 0);
    repeat (3) cyc(1, 0, 1, 0);
    chk("noqueue_state", int'(pres_state_o), 0);

    // Hit priority over a same-cycle frame, odd gun span.
    gun_left_i = 10'd100; gun_right_i = 10'd141;
    cyc(1, 1, 1, 0);
    chk("launch2_left", int'(bullet_left_o), 119);
    chk("launch2_right", int'(bullet_right_o), 122);
    repeat (3) cyc(1, 0, 1, 0);
    chk("fly3_top", int'(bullet_top_o), 407);
    cyc(1, 0, 1, 1);
    chk("hit_state", int'(pres_state_o), 2);
    chk_parked("hit");
    for (int k = 0; k < 7; k++) cyc(1, 0, 1, 0);
    chk("cool7_state", int'(pres_state_o), 2);
    cyc(1, 0, 1, 0);
    chk("cool8_state", int'(pres_state_o), 0);

    // Holding shoot through flight and cooldown.
    cyc(1, 1, 1, 0);
    repeat (2) cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 1, 0);
      cyc(1, 1, 1, 0);
    end
    chk("hold_rearm_state", int'(pres_state_o), 0);
    cyc(1, 1, 1, 0);
`ifdef PLAYER_BULLET_AUTOFIRE_EN
    chk("hold_relaunch", int'(bullet_o), 1);
`else
    chk("hold_relaunch", int'(bullet_o), 0);
`endif
    cyc(0, 0, 0, 0);
    chk("clear_state", int'(pres_state_o), 0);

    // Disable during flight, and shoot edge while disabled.
    cyc(0, 0, 1, 0);
    cyc(1, 1, 1, 0);
    chk("launch3_bullet", int'(bullet_o), 1);
    cyc(0, 0, 0, 0);
    chk("disable_state", int'(pres_state_o), 0);
    chk_parked("disable");
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("dis_shoot_state", int'(pres_state_o), 0);
    cyc(1, 0, 1, 0);
    chk("dis_shoot_after", int'(pres_state_o), 0);

    // Asynchronous reset between clock edges during flight.
    cyc(1, 1, 1, 0);
    cyc(1, 0, 1, 0);
    chk("pre_reset_bullet", int'(bullet_o), 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_state", int'(pres_state_o), 0);
    chk_parked("async");
    reset_i = 1'b0;
    model_reset();
    cyc(0, 0, 1, 0);
    cyc(1, 1, 1, 0);
    chk("relaunch_top", int'(bullet_top_o), 419);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
